// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary stages: default bundle widths and
// the bit positions of the control-bundle fields.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   localparam int CTRL_REGW   = 0;
   localparam int CTRL_MEMR   = 1;
   localparam int CTRL_MEMW   = 2;
   localparam int CTRL_MEMTOR = 3;
   localparam int CTRL_PCSEL  = 4;
   localparam int CTRL_ZERO   = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Reused by any stage that reports stall or event statistics.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] value
);

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the always blocks are evaluated.
   always_ff @(posedge clk) begin
      if (!rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry (head + skid) buffer, so that
// in_ready comes straight from a flop; flush inserts a bubble.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              clr_cnt
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   localparam entry_t EMPTY = '0;

   entry_t     h_q, h_d;
   entry_t     s_q, s_d;
   entry_t     in_e;
   logic       rdy_q;
   logic [1:0] occ_q;
   logic       acc;
   logic       pop;

   assign acc  = in_valid & rdy_q;
   assign pop  = h_q.valid & out_ready;
   assign in_e = '{valid: 1'b1, data: in_data, ctrl: in_ctrl};

   // NOTE: every path starts from the held value, so no branch leaves h_d/s_d
   // unassigned and no latch is inferred.
   always_comb begin
      h_d = h_q;
      s_d = s_q;
      if (flush) begin
         // A pop this cycle has already been taken downstream; an accept is dropped.
         h_d = EMPTY;
         s_d = EMPTY;
      end else if (!h_q.valid) begin
         if (acc) h_d = in_e;
      end else if (pop) begin
         if (s_q.valid) begin
            h_d = s_q;
            s_d = EMPTY;
         end else if (acc) begin
            h_d = in_e;
         end else begin
            h_d = EMPTY;
         end
      end else if (acc) begin
         s_d = in_e;
      end
   end

   // NOTE: the data/ctrl registers are reset along with the valid bits because
   // out_ctrl must read 0 on every invalid slot, including right after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         h_q   <= EMPTY;
         s_q   <= EMPTY;
         rdy_q <= 1'b1;
         occ_q <= 2'd0;
      end else begin
         h_q   <= h_d;
         s_q   <= s_d;
         rdy_q <= !s_d.valid;
         occ_q <= {1'b0, h_d.valid} + {1'b0, s_d.valid};
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = h_q.valid;
   assign out_data  = h_q.data;
   assign out_ctrl  = h_q.ctrl;
   assign occupancy = occ_q;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (h_q.valid & ~out_ready),
      .clr  (clr_cnt),
      .value(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a long random
// run, all compared against a queue-based reference model of the stage.
module tb_pipe_stage_skid;

   localparam int DW      = 32;
   localparam int CW      = 8;
   localparam int NW      = 4;
   localparam int CNT_MAX = (1 << NW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;
   logic          clr_cnt;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_W(DW),
      .CTRL_W(CW),
      .CNT_W (NW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt),
      .clr_cnt  (clr_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: entries held by the stage, oldest first, as {ctrl, data}.
   logic [DW+CW-1:0] q[$];
   int               m_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare();
      logic [CW-1:0] e_ctrl;
      e_ctrl = '0;
      if (q.size() != 0) begin
         e_ctrl = q[0][DW+:CW];
         check("out_data", out_data, q[0][DW-1:0]);
      end
      check("out_valid", out_valid, q.size() != 0);
      check("out_ctrl", out_ctrl, e_ctrl);
      check("in_ready", in_ready, q.size() < 2);
      check("occupancy", occupancy, q.size());
      check("stall_cnt", stall_cnt, m_cnt);
   endtask

   // Drive one cycle of inputs (called at the falling edge), advance the model,
   // then compare at the next falling edge.
   task automatic step(input logic r, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic cl);
      logic [DW+CW-1:0] tmp;
      bit m_acc, m_pop, m_stall;
      rst = r; flush = fl; in_valid = iv; in_data = d; in_ctrl = c;
      out_ready = ordy; clr_cnt = cl;
      if (!r) begin
         q.delete();
         m_cnt = 0;
      end else begin
         m_acc   = iv && (q.size() < 2);
         m_pop   = (q.size() != 0) && ordy;
         m_stall = (q.size() != 0) && !ordy;
         if (cl) m_cnt = 0;
         else if (m_stall && m_cnt < CNT_MAX) m_cnt++;
         if (m_pop) tmp = q.pop_front();
         if (fl) q.delete();
         else if (m_acc) q.push_back({c, d});
      end
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);

      // 1. Reset dominates a valid input.
      repeat (2) step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'h5A, 1'b0, 1'b0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occupancy", occupancy, 0);
      check("rst_stall_cnt", stall_cnt, 0);

      // 2. Streaming with out_ready high: one-cycle latency, skid never used.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 1'b1, DW'(i), 8'h05, 1'b1, 1'b0);
         check("stream_data", out_data, i);
         check("stream_ctrl", out_ctrl, 8'h05);
         check("stream_ready", in_ready, 1);
         check("stream_occ_le1", occupancy <= 2'd1, 1);
      end
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check("stream_drained", out_valid, 0);

      // 3. Backpressure fills head and skid; C waits upstream.
      step(1'b1, 1'b0, 1'b1, 32'h11, 8'h01, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h22, 8'h02, 1'b0, 1'b0);
      check("bp_occ2", occupancy, 2);
      check("bp_ready0", in_ready, 0);
      step(1'b1, 1'b0, 1'b1, 32'h33, 8'h03, 1'b0, 1'b0);
      check("bp_head_a", out_data, 32'h11);
      check("bp_hold_occ", occupancy, 2);
      check("bp_seq0", out_data, 32'h11);
      step(1'b1, 1'b0, 1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
      check("bp_seq1", out_data, 32'h22);
      step(1'b1, 1'b0, 1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
      check("bp_seq2", out_data, 32'h33);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check("bp_empty", out_valid, 0);

      // 4a. Flush with skid full and a push presented.
      step(1'b1, 1'b0, 1'b1, 32'h44, 8'h1F, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h55, 8'h1F, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h66, 8'h1F, 1'b0, 1'b0);
      check("fl_valid", out_valid, 0);
      check("fl_ctrl", out_ctrl, 0);
      check("fl_occ", occupancy, 0);
      check("fl_ready", in_ready, 1);
      repeat (2) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check("fl_no_ghost", out_valid, 0);
      // 4b. Entry accepted in the flush cycle is discarded.
      step(1'b1, 1'b0, 1'b1, 32'h77, 8'h0F, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h88, 8'h0F, 1'b0, 1'b0);
      check("fl_acc_dropped", out_valid, 0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check("fl_acc_dropped2", out_valid, 0);
      // 4c. Flush together with a pop.
      step(1'b1, 1'b0, 1'b1, 32'h99, 8'h0F, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      check("fl_pop_occ", occupancy, 0);

      // 5. Stall counter saturation and clear priority.
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 32'hAB, 8'h08, 1'b0, 1'b0);
      repeat (20) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      check("cnt_saturated", stall_cnt, 15);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      check("cnt_clr_wins", stall_cnt, 0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      check("cnt_restart", stall_cnt, 1);
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      check("cnt_flush_keeps", stall_cnt, 2);

      // 6. Random traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(1999, 0) != 0,
              $urandom_range(49, 0) == 0,
              $urandom_range(99, 0) < 60,
              DW'($urandom),
              CW'($urandom),
              $urandom_range(99, 0) < 60,
              $urandom_range(199, 0) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
